// File: rtl/regex_pkg.sv
// Shared definitions for regex leaf matchers: default character width,
// character type and the class-membership helper used by class leaves.
package regex_pkg;

    localparam int unsigned CHAR_W = 8;

    typedef logic [CHAR_W-1:0] char_t;

    // Inclusive unsigned range test, optionally inverted.
    function automatic logic in_class(input char_t c, input char_t lo, input char_t hi,
                                      input logic neg);
        return ((c >= lo) && (c <= hi)) ^ neg;
    endfunction

endpackage : regex_pkg

// File: rtl/char_class_cmp.sv
// Purely combinational character-class compare: hit = (LO <= c <= HI) ^ NEGATE.
module char_class_cmp
    import regex_pkg::*;
#(
    parameter int unsigned    CW     = CHAR_W,
    parameter logic [CW-1:0]  LO     = 8'h30,
    parameter logic [CW-1:0]  HI     = 8'h39,
    parameter bit             NEGATE = 1'b0
) (
    input  logic [CW-1:0] c,
    output logic          hit
);

    // The shared helper is fixed at the package width; other widths compare inline.
    if (CW == CHAR_W) begin : g_pkg_cmp
        assign hit = in_class(char_t'(c), char_t'(LO), char_t'(HI), NEGATE);
    end else begin : g_wide_cmp
        assign hit = ((c >= LO) && (c <= HI)) ^ NEGATE;
    end

endmodule : char_class_cmp

// File: rtl/char_class_repeat.sv
// Regex leaf matching [LO-HI]{MIN,MAX} (optionally negated). Every in-flight
// repetition count is tracked as one bit of a one-hot-per-activation vector, so
// overlapping activations coexist. Characters are consumed only when en is high.
module char_class_repeat
    import regex_pkg::*;
#(
    parameter int unsigned    CW     = CHAR_W,
    parameter logic [CW-1:0]  LO     = 8'h30,
    parameter logic [CW-1:0]  HI     = 8'h39,
    parameter bit             NEGATE = 1'b0,
    parameter int unsigned    MIN    = 1,
    parameter int unsigned    MAX    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          i,
    input  logic [CW-1:0] i_c,
    output logic          o
);

    if (MIN == 0 || MIN > MAX || MAX > 64 || LO > HI) begin : g_bad_params
        $error("char_class_repeat: illegal parameters (need 1 <= MIN <= MAX <= 64, LO <= HI)");
    end

    logic           hit;
    // q_q[k] set: exactly k consecutive class characters since some activation.
    logic [MAX:1]   q_q;
    logic [MAX:1]   q_d;

    char_class_cmp #(
        .CW     (CW),
        .LO     (LO),
        .HI     (HI),
        .NEGATE (NEGATE)
    ) u_cmp (
        .c   (i_c),
        .hit (hit)
    );

    // Advance every count by one on a class character; a miss clears the whole vector.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d[1] = i & hit;
            for (int k = 2; k <= MAX; k++) begin
                q_d[k] = q_q[k-1] & hit;
            end
        end
    end

    // Count register; asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Registered-only output: no combinational path from inputs.
    assign o = |q_q[MAX:MIN];

endmodule : char_class_repeat

// File: tb/tb_char_class_repeat.sv
// Scoreboard bench for char_class_repeat: four parameterisations, directed
// vectors push the expected o per edge; a monitor pops and compares after each edge.
module tb_char_class_repeat;

    logic       clk;
    logic       reset;
    logic       en_v [4];
    logic       i_v  [4];
    logic [7:0] c_v  [4];
    logic       o_v  [4];

    int n_pass;
    int n_total;

    logic exp_q0 [$];
    logic exp_q1 [$];
    logic exp_q2 [$];
    logic exp_q3 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digits {1,4}.
    char_class_repeat u_d0 (
        .clk (clk), .reset (reset), .en (en_v[0]), .i (i_v[0]), .i_c (c_v[0]), .o (o_v[0])
    );

    // Lowercase {2,3}.
    char_class_repeat #(.LO(8'h61), .HI(8'h7A), .MIN(2), .MAX(3)) u_d1 (
        .clk (clk), .reset (reset), .en (en_v[1]), .i (i_v[1]), .i_c (c_v[1]), .o (o_v[1])
    );

    // Lowercase {2,2}.
    char_class_repeat #(.LO(8'h61), .HI(8'h7A), .MIN(2), .MAX(2)) u_d2 (
        .clk (clk), .reset (reset), .en (en_v[2]), .i (i_v[2]), .i_c (c_v[2]), .o (o_v[2])
    );

    // Not-comma {1,1}.
    char_class_repeat #(.LO(8'h2C), .HI(8'h2C), .NEGATE(1'b1), .MIN(1), .MAX(1)) u_d3 (
        .clk (clk), .reset (reset), .en (en_v[3]), .i (i_v[3]), .i_c (c_v[3]), .o (o_v[3])
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: o=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one character cycle on DUT d and record the o expected after the edge.
    task automatic step(input int d, input logic e, input logic a, input logic [7:0] ch,
                        input logic exp);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            en_v[k] = 1'b0;
            i_v[k]  = 1'b0;
        end
        en_v[d] = e;
        i_v[d]  = a;
        c_v[d]  = ch;
        case (d)
            0: exp_q0.push_back(exp);
            1: exp_q1.push_back(exp);
            2: exp_q2.push_back(exp);
            default: exp_q3.push_back(exp);
        endcase
    endtask

    task automatic idle();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            en_v[k] = 1'b0;
            i_v[k]  = 1'b0;
        end
    endtask

    // Monitor: after every edge, compare each DUT that has a pending expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q0.size() > 0) chk($sformatf("d0_digits_1_4 #%0d", n_total), o_v[0],
                                   exp_q0.pop_front());
        if (exp_q1.size() > 0) chk($sformatf("d1_lower_2_3 #%0d", n_total), o_v[1],
                                   exp_q1.pop_front());
        if (exp_q2.size() > 0) chk($sformatf("d2_lower_2_2 #%0d", n_total), o_v[2],
                                   exp_q2.pop_front());
        if (exp_q3.size() > 0) chk($sformatf("d3_notcomma_1_1 #%0d", n_total), o_v[3],
                                   exp_q3.pop_front());
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            en_v[k] = 1'b0;
            i_v[k]  = 1'b0;
            c_v[k]  = 8'h00;
        end
        #2;
        for (int k = 0; k < 4; k++) chk($sformatf("reset_o_d%0d", k), o_v[k], 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Digits: "7" activates, "2","5" extend, "a" clears.
        step(0, 1, 1, "7", 1);
        step(0, 1, 0, "2", 1);
        step(0, 1, 0, "5", 1);
        step(0, 1, 0, "a", 0);
        // Run past MAX: fifth digit has no successor bit.
        step(0, 1, 1, "7", 1);
        step(0, 1, 0, "1", 1);
        step(0, 1, 0, "2", 1);
        step(0, 1, 0, "3", 1);
        step(0, 1, 0, "4", 0);
        // Class boundaries: '/' and ':' outside, '0' and '9' inside.
        step(0, 1, 1, "/", 0);
        step(0, 1, 1, ":", 0);
        step(0, 1, 1, "0", 1);
        step(0, 1, 0, "9", 1);
        step(0, 1, 0, "x", 0);

        // Stall with q[2] set: junk on i and i_c while en is low.
        step(0, 1, 1, "3", 1);
        step(0, 1, 0, "4", 1);
        step(0, 0, 1, "x", 1);
        step(0, 0, 1, "x", 1);
        step(0, 0, 1, "x", 1);
        step(0, 1, 0, "5", 1);
        step(0, 1, 0, "6", 1);
        step(0, 1, 0, "7", 0);

        // {2,3}: counts 1,2,3,4.
        step(1, 1, 1, "x", 0);
        step(1, 1, 0, "y", 1);
        step(1, 1, 0, "z", 1);
        step(1, 1, 0, "w", 0);

        // {2,2} overlap: activations on "b" and "c".
        step(2, 1, 1, "b", 0);
        step(2, 1, 1, "c", 1);
        step(2, 1, 0, "d", 1);
        step(2, 1, 0, "e", 0);
        // Non-class character clears both in-flight counts.
        step(2, 1, 1, "b", 0);
        step(2, 1, 1, "c", 1);
        step(2, 1, 0, "!", 0);
        step(2, 1, 0, "d", 0);

        // Negated comma class.
        step(3, 1, 1, "a", 1);
        step(3, 1, 1, ",", 0);
        step(3, 1, 0, "a", 0);

        // Asynchronous reset mid-run.
        step(0, 1, 1, "1", 1);
        step(0, 1, 0, "2", 1);
        idle();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_immediate", o_v[0], 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held", o_v[0], 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 1, "8", 1);
        step(0, 1, 0, "9", 1);
        step(0, 1, 0, "a", 0);
        idle();
        repeat (3) @(posedge clk);
        #2;

        n_total++;
        if (exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: pending=%0d expected 0",
                     exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_char_class_repeat
